// File: rtl/bcd_disp_pkg.sv
// Shared types and seven-segment decode for the BCD up/down display.
package bcd_disp_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low, bit order G..A; non-decimal codes blank the digit.
   function automatic logic [6:0] seg7_decode(input bcd_digit_t d);
      case (d)
         4'd0:    seg7_decode = 7'b1000000;
         4'd1:    seg7_decode = 7'b1111001;
         4'd2:    seg7_decode = 7'b0100100;
         4'd3:    seg7_decode = 7'b0110000;
         4'd4:    seg7_decode = 7'b0011001;
         4'd5:    seg7_decode = 7'b0010010;
         4'd6:    seg7_decode = 7'b0000010;
         4'd7:    seg7_decode = 7'b1111000;
         4'd8:    seg7_decode = 7'b0000000;
         4'd9:    seg7_decode = 7'b0010000;
         default: seg7_decode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_updown_display_tick_gen.sv
// Single-cycle strobe generator: tick is high while the divider sits at DIV-1.
module tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with load/enable driving a multiplexed active-low
// seven-segment display. Define BCD_DISP_SATURATE_EN to hold at the bounds.
module bcd_updown_display
   import bcd_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_HZ     = 100_000_000,
   parameter int COUNT_HZ   = 1,
   parameter int SCAN_HZ    = 800
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    direction,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_bcd,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    carry,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    tick_count,
   output logic                    tick_scan
);

   localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
   localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
   localparam int W         = 4 * NUM_DIGITS;
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

   // Returns {wrap, value}; wrap is the carry out of the top digit.
   function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
      logic       c;
      bcd_digit_t d;
      logic [W-1:0] r;
      c = 1'b1;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (d == 4'd9) begin
               d = 4'd0;
            end else begin
               d = d + 4'd1;
               c = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return {c, r};
   endfunction

   // Returns {wrap, value}; wrap is the borrow out of the top digit.
   function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
      logic       b;
      bcd_digit_t d;
      logic [W-1:0] r;
      b = 1'b1;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = v[4*i +: 4];
         if (b) begin
            if (d == 4'd0) begin
               d = 4'd9;
            end else begin
               d = d - 4'd1;
               b = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return {b, r};
   endfunction

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   logic             step;
   logic             wrap;
   logic [W-1:0]     stepped;
   logic [W-1:0]     count_n;
   logic [IDX_W-1:0] scan_idx;
   logic [NUM_DIGITS-1:0] an_n;

   tick_gen #(.DIV(COUNT_DIV)) u_count_tick (
      .clk   (clk),
      .reset (reset),
      .clear (load),
      .tick  (tick_count)
   );

   tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .tick  (tick_scan)
   );

   always_comb begin
      step = tick_count && enable && !load;
      {wrap, stepped} = direction ? bcd_dec(count_bcd) : bcd_inc(count_bcd);
      count_n = count_bcd;
      if (load) begin
         count_n = bcd_clamp(load_bcd);
      end else if (step) begin
`ifdef BCD_DISP_SATURATE_EN
         if (!wrap) count_n = stepped;
`else
         count_n = stepped;
`endif
      end
      an_n = '1;
      an_n[scan_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_bcd <= '0;
         carry     <= 1'b0;
         scan_idx  <= '0;
         an        <= '1;
         seg       <= SEG_BLANK;
      end else begin
         count_bcd <= count_n;
`ifdef BCD_DISP_SATURATE_EN
         carry     <= (count_n == (direction ? '0 : ALL_NINES));
`else
         carry     <= step && wrap;
`endif
         if (tick_scan) begin
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end
         // Display stage lags the scan index and count by one register.
         an  <= an_n;
         seg <= seg7_decode(count_bcd[4*scan_idx +: 4]);
      end
   end

endmodule
